seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// hex-to-segment table, blanking codes and digit count.
package seg_pkg;

    localparam int DIGITS = 4;

    localparam logic [7:0] BLANK_SEG = 8'h00;
    localparam logic [3:0] ALL_OFF   = 4'b1111;

    // Segment codes indexed by hex value; bit7..bit1 = a..g, bit0 (dp) clear.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E D C
        8'h3E, 8'hEE, 8'hF6, 8'hFE,   // B A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to a..g segment lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[hex][7:1];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with a double-buffered frame
// load port; new frames are swapped in only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 200,
    parameter int BLANK = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  load_en,
    output logic [7:0]  display,
    output logic [3:0]  control,
    output logic        frame_done
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0]  BLANK_C = CW'(BLANK);
    localparam logic [1:0]     TOP_DIG = 2'(DIGITS - 1);

    logic [CW-1:0] count, count_nxt;
    logic [1:0]    digit, digit_nxt;
    logic          armed;

    logic [15:0]   act_data, act_data_nxt, sh_data;
    logic [3:0]    act_dp, act_dp_nxt, sh_dp;
    logic [3:0]    act_en, act_en_nxt, sh_en;
    logic          sh_full, sh_full_nxt;

    logic          handshake, frame_end, swap, lit;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic [7:0]    display_nxt;
    logic [3:0]    control_nxt;
    logic          fd_nxt;

    seg_hex_decode u_dec (
        .hex (nibble),
        .seg (seg7)
    );

    // Outputs are registered from the next-state values so that in every
    // cycle they match that cycle's count/digit and active content.
    always_comb begin
        handshake = load_valid && load_ready;
        frame_end = armed && (count == LAST) && (digit == 2'd0);
        swap      = frame_end && sh_full;

        count_nxt = '0;
        digit_nxt = TOP_DIG;
        if (armed) begin
            if (count == LAST) begin
                count_nxt = '0;
                digit_nxt = 2'(digit - 2'd1);
            end else begin
                count_nxt = count + 1'b1;
                digit_nxt = digit;
            end
        end

        act_data_nxt = swap ? sh_data : act_data;
        act_dp_nxt   = swap ? sh_dp   : act_dp;
        act_en_nxt   = swap ? sh_en   : act_en;

        // Handshake and swap are exclusive: ready is low whenever a swap is possible.
        sh_full_nxt = sh_full;
        if (handshake) begin
            sh_full_nxt = 1'b1;
        end else if (swap) begin
            sh_full_nxt = 1'b0;
        end

        nibble      = act_data_nxt[{digit_nxt, 2'b00} +: 4];
        lit         = (count_nxt >= BLANK_C) && act_en_nxt[digit_nxt];
        control_nxt = lit ? ~(4'b0001 << digit_nxt) : ALL_OFF;
        display_nxt = lit ? {seg7, act_dp_nxt[digit_nxt]} : BLANK_SEG;
        fd_nxt      = (count_nxt == LAST) && (digit_nxt == 2'd0);
    end

    // The first clock after reset release is an arming cycle: the counter
    // holds at 0 / digit 3 while load_ready comes up.
    always_ff @(posedge clk) begin
        if (!reset) begin
            armed      <= 1'b0;
            count      <= '0;
            digit      <= TOP_DIG;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            sh_full    <= 1'b0;
            control    <= ALL_OFF;
            display    <= BLANK_SEG;
            frame_done <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            armed      <= 1'b1;
            count      <= count_nxt;
            digit      <= digit_nxt;
            act_data   <= act_data_nxt;
            act_dp     <= act_dp_nxt;
            act_en     <= act_en_nxt;
            if (handshake) begin
                sh_data <= load_data;
                sh_dp   <= load_dp;
                sh_en   <= load_en;
            end
            sh_full    <= sh_full_nxt;
            control    <= control_nxt;
            display    <= display_nxt;
            frame_done <= fd_nxt;
            load_ready <= !sh_full_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=10, BLANK=2 (40-cycle frames).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [3:0]  load_en;
    logic [7:0]  display;
    logic [3:0]  control;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_ctrl #(.DIV(10), .BLANK(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_en    (load_en),
        .display    (display),
        .control    (control),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer a frame from a negedge; returns at the negedge after the transfer.
    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        bit done;
        done = 1'b0;
        load_data  = d;
        load_dp    = dp;
        load_en    = en;
        load_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (load_ready === 1'b1) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL load_timeout: load_ready stayed 0 for 100 cycles, required 1");
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Advance negedge by negedge until frame_done is seen (current cycle included).
    task automatic wait_fd(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (frame_done === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_fd_timeout: frame_done not seen in 100 cycles, required 1", tag);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        load_dp    = 4'hF;
        load_en    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (control !== 4'b1111 || display !== 8'h00 || load_ready !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got ctrl=%b disp=%h rdy=%b fd=%b, required 1111/00/0/0",
                         i, control, display, load_ready, frame_done);
            end
        end
        load_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        // Blank frame after release: ready stays high, frame_done only at index 39.
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== 4'b1111 || display !== 8'h00 || load_ready !== 1'b1 || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got ctrl=%b disp=%h rdy=%b fd=%b, required 1111/00/1/%0d",
                         i, control, display, load_ready, frame_done, (i == 39));
            end
        end
    endtask

    task automatic test_display();
        logic [3:0] ec [4];
        logic [7:0] ed [4];
        ec = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        ed = '{8'h60, 8'hDA, 8'hF2, 8'h67};
        do_load(16'h1234, 4'b0001, 4'b1111);
        wait_fd("display");
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : ed[i / 10]) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL display_1234[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : ed[i / 10]), (i == 39));
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] ec [4];
        logic [7:0] ed [4];
        // Digit 2 holds nibble B, digit 0 holds nibble D; digits 3 and 1 disabled.
        ec = '{4'b1111, 4'b1011, 4'b1111, 4'b1110};
        ed = '{8'h00, 8'h3E, 8'h00, 8'h7A};
        do_load(16'hABCD, 4'b0000, 4'b0101);
        wait_fd("enable");
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : ed[i / 10]) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL enable_abcd[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : ed[i / 10]), (i == 39));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ec [4];
        bit prev_fd;
        bit seen;
        ec = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        do_load(16'h1111, 4'b0000, 4'b1111);
        load_data  = 16'h2222;
        load_dp    = 4'b0000;
        load_en    = 4'b1111;
        load_valid = 1'b1;
        prev_fd = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (load_ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                prev_fd = frame_done;
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen || prev_fd !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall: ready seen=%0d prev_fd=%b, required ready=1 right after frame_done",
                     seen, prev_fd);
        end
        // This cycle is slot 0 of the 1111 frame; the second transfer happens at its end.
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) begin
                load_valid = 1'b0;
                n_checks++;
                if (load_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_low: got rdy=%b, required 0", load_ready);
                end
            end
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : 8'h60) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL b2b_1111[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : 8'h60), (i == 39));
            end
        end
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : 8'hDA) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL b2b_2222[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : 8'hDA), (i == 39));
            end
        end
    endtask

    // Entered at the frame_done cycle of the 2222 frame with the shadow empty.
    task automatic test_fd_handshake();
        logic [3:0] ec [4];
        logic [7:0] ed [4];
        ec = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        ed = '{8'hB6, 8'hBE, 8'hE0, 8'hFE};
        n_checks++;
        if (frame_done !== 1'b1 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fdhs_entry: got fd=%b rdy=%b, required 1/1", frame_done, load_ready);
        end
        load_data  = 16'h5678;
        load_dp    = 4'b0000;
        load_en    = 4'b1111;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : 8'hDA) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL fdhs_old[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : 8'hDA), (i == 39));
            end
        end
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== ((i % 10) < 2 ? 4'b1111 : ec[i / 10]) ||
                display !== ((i % 10) < 2 ? 8'h00 : ed[i / 10]) || frame_done !== (i == 39)) begin
                n_fail++;
                $display("FAIL fdhs_new[%0d]: got ctrl=%b disp=%h fd=%b, required %b/%h/%0d", i,
                         control, display, frame_done, ((i % 10) < 2 ? 4'b1111 : ec[i / 10]),
                         ((i % 10) < 2 ? 8'h00 : ed[i / 10]), (i == 39));
            end
        end
    endtask

    // Entered at a frame_done cycle with the shadow empty.
    task automatic test_reset_mid();
        load_data  = 16'h9999;
        load_dp    = 4'b1111;
        load_en    = 4'b1111;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        // Index 25 of the frame is digit 1, count 5.
        for (int i = 1; i <= 25; i++) @(negedge clk);
        n_checks++;
        if (load_ready !== 1'b0 || control !== 4'b1101) begin
            n_fail++;
            $display("FAIL rmid_pending: got rdy=%b ctrl=%b, required 0/1101", load_ready, control);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (control !== 4'b1111 || display !== 8'h00 || load_ready !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_reset[%0d]: got ctrl=%b disp=%h rdy=%b fd=%b, required 1111/00/0/0",
                         i, control, display, load_ready, frame_done);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (control !== 4'b1111 || display !== 8'h00 || load_ready !== 1'b1 ||
                frame_done !== (i == 39 || i == 79)) begin
                n_fail++;
                $display("FAIL rmid_blank[%0d]: got ctrl=%b disp=%h rdy=%b fd=%b, required 1111/00/1/%0d",
                         i, control, display, load_ready, frame_done, (i == 39 || i == 79));
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_dp    = 4'h0;
        load_en    = 4'h0;
        test_reset();
        test_display();
        test_enable();
        test_back_to_back();
        test_fd_handshake();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
